// File: rtl/ahb_cmd_master.sv
// AHB-Lite single-transfer initiator: valid/ready command in, one NONSEQ transfer out, one response pulse back.
// Optional abort on a stuck bus is compiled in with `define AHB_MST_TIMEOUT_EN.
module ahb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        timeout_flag,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic [31:0] hrdata,
  input  logic [1:0]  hresp
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("ahb_cmd_master: TIMEOUT_CYCLES out of range 2..65535");
  end

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t      state, state_d;
  logic [31:0] addr_q, wdata_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        accept, cmd_bad, bus_err, tmo_hit;
  logic        rsp_load, rsp_err_d;
  logic [31:0] rsp_rdata_d, rd_lane;

  // Handshake: a command moves only on a cycle where cmd_valid and cmd_ready are both high;
  // cmd_ready depends on state alone, never on cmd_valid.
  assign cmd_ready = (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_bad   = (cmd_size == 2'd3) ||
                     (cmd_size == 2'd1 && cmd_addr[0]) ||
                     (cmd_size == 2'd2 && cmd_addr[1:0] != 2'b00);
  assign bus_err   = (hresp != 2'b00);

  assign rsp_valid = (state == S_RESP);
  assign htrans    = (state == S_ADDR) ? 2'b10 : 2'b00;
  assign haddr     = addr_q;
  assign hwrite    = write_q;
  assign hsize     = {1'b0, size_q};
  assign hburst    = 3'b000;

  always_comb begin
    case (size_q)
      2'd0:    hwdata = {4{wdata_q[7:0]}};
      2'd1:    hwdata = {2{wdata_q[15:0]}};
      default: hwdata = wdata_q;
    endcase
  end

  // Right-align the addressed lane of the read bus, zero-extended.
  always_comb begin
    rd_lane = '0;
    case (size_q)
      2'd0:    rd_lane[7:0]  = hrdata[{addr_q[1:0], 3'b000} +: 8];
      2'd1:    rd_lane[15:0] = hrdata[{addr_q[1], 4'b0000} +: 16];
      default: rd_lane       = hrdata;
    endcase
  end

  always_comb begin
    state_d     = state;
    rsp_load    = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (cmd_bad) begin
            state_d   = S_RESP;
            rsp_load  = 1'b1;
            rsp_err_d = 1'b1;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (tmo_hit) begin
          state_d   = S_RESP;
          rsp_load  = 1'b1;
          rsp_err_d = 1'b1;
        end else if (hready) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tmo_hit) begin
          state_d   = S_RESP;
          rsp_load  = 1'b1;
          rsp_err_d = 1'b1;
        end else if (hready) begin
          state_d     = S_RESP;
          rsp_load    = 1'b1;
          rsp_err_d   = bus_err;
          rsp_rdata_d = (bus_err || write_q) ? 32'h0 : rd_lane;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= S_IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      size_q    <= 2'd0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        write_q <= cmd_write;
        size_q  <= cmd_size;
      end
      if (rsp_load) begin
        rsp_err   <= rsp_err_d;
        rsp_rdata <= rsp_rdata_d;
      end
    end
  end

`ifdef AHB_MST_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Hit on the last permitted ADDR/DATA cycle so the abort edge is the TIMEOUT_CYCLES-th one.
  assign tmo_hit = (state == S_ADDR || state == S_DATA) &&
                   (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      tmo_cnt      <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (accept)                                     tmo_cnt <= '0;
      else if (state == S_ADDR || state == S_DATA)    tmo_cnt <= tmo_cnt + 16'd1;
      if (accept)       timeout_flag <= 1'b0;
      else if (tmo_hit) timeout_flag <= 1'b1;
    end
  end
`else
  assign tmo_hit      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Bench for ahb_cmd_master: the bench plays the AHB slave, drives commands and checks responses
// against a reference model of the command/response rules.
module tb_ahb_cmd_master;
`ifdef AHB_MST_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_size;
  logic        rsp_valid, rsp_err, timeout_flag;
  logic [31:0] rsp_rdata, haddr, hwdata, hrdata;
  logic [1:0]  htrans, hresp;
  logic        hwrite, hready;
  logic [2:0]  hsize, hburst;

  ahb_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .timeout_flag(timeout_flag),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hwdata(hwdata),
    .hready(hready), .hrdata(hrdata), .hresp(hresp)
  );

  // Clock / reset
  always #5 hclk = ~hclk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // Observations of the most recent command
  int          obs_lat, obs_nonseq;
  logic        obs_got, obs_err, obs_stable, obs_hwrite;
  logic [31:0] obs_rdata, obs_haddr, obs_hwdata;
  logic [2:0]  obs_hsize;

  // Reference model
  function automatic bit ref_bad(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    return (a % (32'd1 << sz)) != 0;
  endfunction

  function automatic logic [31:0] ref_lane(input logic [31:0] d, input logic [31:0] a,
                                           input logic [1:0] sz);
    logic [31:0] sh;
    sh = d >> (8 * (a % 4));
    if (sz == 2'd0) return sh & 32'h0000_00FF;
    if (sz == 2'd1) return sh & 32'h0000_FFFF;
    return d;
  endfunction

  function automatic logic [31:0] ref_hwdata(input logic [31:0] wd, input logic [1:0] sz);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  // Driver: issue one command and act as the slave (aw address waits, dw data waits).
  task automatic run_cmd(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] wd, input int aw, input int dw,
                         input logic se, input logic [31:0] sd);
    int aw_left = aw;
    int dw_left = dw;
    bit pend = 0, in_data = 0, first_a = 1, first_d = 1;
    obs_got = 0; obs_lat = -1; obs_nonseq = 0; obs_stable = 1;
    obs_err = 0; obs_rdata = 0; obs_haddr = 0; obs_hwdata = 0; obs_hsize = 0; obs_hwrite = 0;
    @(negedge hclk);
    hready = 1; hresp = 2'b00;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
    for (int n = 1; n <= 200 && !obs_got; n++) begin
      @(negedge hclk);
      if (n == 1) begin
        cmd_valid = 0; cmd_write = 1'($urandom_range(0, 1)); cmd_addr = $urandom;
        cmd_size = 2'($urandom_range(0, 3)); cmd_wdata = $urandom;
      end
      if (pend) begin in_data = 1; pend = 0; end
      if (rsp_valid) begin
        obs_got = 1; obs_lat = n; obs_err = rsp_err; obs_rdata = rsp_rdata;
        hready = 1; hresp = 2'b00;
      end else if (htrans == 2'b10) begin
        obs_nonseq++;
        if (first_a) begin
          obs_haddr = haddr; obs_hsize = hsize; obs_hwrite = hwrite; first_a = 0;
        end else if (haddr !== obs_haddr || hsize !== obs_hsize || hwrite !== obs_hwrite) begin
          obs_stable = 0;
        end
        hresp = 2'b00;
        if (aw_left > 0) begin hready = 0; aw_left--; end
        else begin hready = 1; pend = 1; end
      end else if (in_data) begin
        if (first_d) begin obs_hwdata = hwdata; first_d = 0; end
        else if (hwdata !== obs_hwdata) obs_stable = 0;
        if (dw_left > 0) begin
          hready = 0; hresp = (se && dw_left == 1) ? 2'b01 : 2'b00; hrdata = $urandom; dw_left--;
        end else begin
          hready = 1; hresp = se ? 2'b01 : 2'b00; hrdata = sd; in_data = 0;
        end
      end else begin
        hready = 1; hresp = 2'b00; hrdata = $urandom;
      end
    end
    hready = 1; hresp = 2'b00;
  endtask

  task automatic test_reset();
    hresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_size = 0; cmd_wdata = 0;
    hready = 1; hresp = 2'b00; hrdata = 0;
    repeat (3) @(negedge hclk);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (htrans !== 2'b00) begin failures++; $display("FAIL reset_htrans got=%b exp=00", htrans); end
    checks++; if (haddr !== 32'h0) begin failures++; $display("FAIL reset_haddr got=%h exp=0", haddr); end
    checks++; if (hwdata !== 32'h0) begin failures++; $display("FAIL reset_hwdata got=%h exp=0", hwdata); end
    checks++; if (hwrite !== 1'b0 || hsize !== 3'b000 || hburst !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl got hwrite=%b hsize=%b hburst=%b exp 0/000/000", hwrite, hsize, hburst); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rsp got v=%b e=%b d=%h exp 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if (timeout_flag !== 1'b0) begin failures++; $display("FAIL reset_timeout_flag got=%b exp=0", timeout_flag); end
    hresetn = 1;
  endtask

  typedef struct {
    logic wr; logic [31:0] a; logic [1:0] sz; logic [31:0] wd; int aw; int dw;
    logic se; logic [31:0] sd; int lat; logic err; logic [31:0] rd; logic [31:0] hw; int ns;
  } dir_t;

  task automatic test_directed();
    dir_t t[7];
    t[0] = '{1'b1, 32'h8000_0000, 2'd2, 32'h1234_5678, 0, 0, 1'b0, 32'h0,         3, 1'b0, 32'h0,  32'h1234_5678, 1};
    t[1] = '{1'b0, 32'h8000_0006, 2'd0, 32'h0,         0, 0, 1'b0, 32'hAABB_CCDD, 3, 1'b0, 32'hBB, 32'h0,         1};
    t[2] = '{1'b1, 32'h8000_0002, 2'd1, 32'hFFFF_BEEF, 0, 0, 1'b0, 32'h0,         3, 1'b0, 32'h0,  32'hBEEF_BEEF, 1};
    t[3] = '{1'b0, 32'h8000_0004, 2'd2, 32'h0,         0, 3, 1'b0, 32'hCAFE_F00D, 6, 1'b0, 32'hCAFE_F00D, 32'h0,  1};
    t[4] = '{1'b0, 32'h8000_0008, 2'd2, 32'h0,         0, 1, 1'b1, 32'hDEAD_BEEF, 4, 1'b1, 32'h0,  32'h0,         1};
    t[5] = '{1'b1, 32'h8000_0002, 2'd2, 32'h1122_3344, 0, 0, 1'b0, 32'h0,         1, 1'b1, 32'h0,  32'h0,         0};
    t[6] = '{1'b1, 32'h8000_000C, 2'd0, 32'h0000_00A5, 2, 0, 1'b0, 32'h0,         5, 1'b0, 32'h0,  32'hA5A5_A5A5, 3};
    for (int i = 0; i < 7; i++) begin
      run_cmd(t[i].wr, t[i].a, t[i].sz, t[i].wd, t[i].aw, t[i].dw, t[i].se, t[i].sd);
      checks++; if (obs_lat !== t[i].lat) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, obs_lat, t[i].lat); end
      checks++; if (obs_err !== t[i].err) begin failures++; $display("FAIL dir%0d_rsp_err got=%b exp=%b", i, obs_err, t[i].err); end
      checks++; if (obs_rdata !== t[i].rd) begin failures++; $display("FAIL dir%0d_rsp_rdata got=%h exp=%h", i, obs_rdata, t[i].rd); end
      checks++; if (obs_nonseq !== t[i].ns) begin failures++; $display("FAIL dir%0d_nonseq_cycles got=%0d exp=%0d", i, obs_nonseq, t[i].ns); end
      checks++; if (obs_stable !== 1'b1) begin failures++; $display("FAIL dir%0d_stable got=%b exp=1", i, obs_stable); end
      if (t[i].ns > 0) begin
        checks++; if (obs_haddr !== t[i].a || obs_hsize !== {1'b0, t[i].sz} || obs_hwrite !== t[i].wr) begin
          failures++; $display("FAIL dir%0d_addr_phase got=%h/%b/%b exp=%h/%b/%b", i, obs_haddr, obs_hsize,
                               obs_hwrite, t[i].a, {1'b0, t[i].sz}, t[i].wr); end
        if (t[i].wr) begin
          checks++; if (obs_hwdata !== t[i].hw) begin failures++; $display("FAIL dir%0d_hwdata got=%h exp=%h", i, obs_hwdata, t[i].hw); end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic wr, se, bad;
      logic [1:0] sz;
      logic [31:0] a, wd, sd, exp_rd;
      int aw, dw;
      wr = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3));
      a  = 32'h8000_0000 | ($urandom & 32'h0000_0FFC) |
           ($urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : 32'h0);
      wd = $urandom; sd = $urandom;
      aw = $urandom_range(0, 2); dw = $urandom_range(0, 3);
      se = ($urandom_range(0, 4) == 0);
      if (se && dw == 0) dw = 1;
      bad = ref_bad(a, sz);
      exp_rd = (bad || se || wr) ? 32'h0 : ref_lane(sd, a, sz);
      exp_q.push_back(exp_rd);
      run_cmd(wr, a, sz, wd, aw, dw, se, sd);
      checks++; if (obs_rdata !== exp_q[0]) begin failures++; $display("FAIL rnd%0d_rsp_rdata got=%h exp=%h", i, obs_rdata, exp_q[0]); end
      void'(exp_q.pop_front());
      checks++; if (obs_err !== (bad || se)) begin failures++; $display("FAIL rnd%0d_rsp_err got=%b exp=%b", i, obs_err, bad || se); end
      checks++; if (obs_lat !== (bad ? 1 : 3 + aw + dw)) begin
        failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, obs_lat, bad ? 1 : 3 + aw + dw); end
      checks++; if (obs_nonseq !== (bad ? 0 : aw + 1)) begin
        failures++; $display("FAIL rnd%0d_nonseq_cycles got=%0d exp=%0d", i, obs_nonseq, bad ? 0 : aw + 1); end
      checks++; if (obs_stable !== 1'b1) begin failures++; $display("FAIL rnd%0d_stable got=%b exp=1", i, obs_stable); end
      if (!bad) begin
        checks++; if (obs_haddr !== a || obs_hsize !== {1'b0, sz} || obs_hwrite !== wr) begin
          failures++; $display("FAIL rnd%0d_addr_phase got=%h/%b/%b exp=%h/%b/%b", i, obs_haddr, obs_hsize,
                               obs_hwrite, a, {1'b0, sz}, wr); end
        if (wr) begin
          checks++; if (obs_hwdata !== ref_hwdata(wd, sz)) begin
            failures++; $display("FAIL rnd%0d_hwdata got=%h exp=%h", i, obs_hwdata, ref_hwdata(wd, sz)); end
        end
      end
    end
  endtask

  // cmd_valid held high: each transfer takes IDLE, ADDR, DATA, RESP, so 40 cycles carry 10 transfers.
  task automatic test_back_to_back();
    int n_rsp = 0, n_ns = 0, viol = 0;
    bit prev_ns = 0;
    @(negedge hclk);
    hready = 1; hresp = 2'b00;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h8000_0100; cmd_size = 2'd2; cmd_wdata = $urandom;
    for (int n = 1; n <= 40; n++) begin
      @(negedge hclk);
      if (rsp_valid) n_rsp++;
      if (htrans == 2'b10) begin n_ns++; if (prev_ns) viol++; end
      prev_ns = (htrans == 2'b10);
    end
    cmd_valid = 0;
    checks++; if (n_rsp !== 10) begin failures++; $display("FAIL b2b_rsp_count got=%0d exp=10", n_rsp); end
    checks++; if (n_ns !== 10) begin failures++; $display("FAIL b2b_nonseq_count got=%0d exp=10", n_ns); end
    checks++; if (viol !== 0) begin failures++; $display("FAIL b2b_consecutive_nonseq got=%0d exp=0", viol); end
    @(negedge hclk);
  endtask

  task automatic test_reset_mid();
    int n_rsp = 0, n_ns = 0;
    @(negedge hclk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h8000_0010; cmd_size = 2'd2;
    @(negedge hclk);
    cmd_valid = 0; hready = 0;
    checks++; if (htrans !== 2'b10) begin failures++; $display("FAIL mid_pre_htrans got=%b exp=10", htrans); end
    hresetn = 0;
    #1;
    checks++; if (htrans !== 2'b00 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL mid_async_reset got htrans=%b cmd_ready=%b exp 00/1", htrans, cmd_ready); end
    @(negedge hclk);
    hresetn = 1; hready = 1;
    for (int n = 0; n < 8; n++) begin
      @(negedge hclk);
      if (rsp_valid) n_rsp++;
      if (htrans == 2'b10) n_ns++;
    end
    checks++; if (n_rsp !== 0 || n_ns !== 0) begin
      failures++; $display("FAIL mid_abandon got rsp=%0d nonseq=%0d exp 0/0", n_rsp, n_ns); end
  endtask

`ifdef AHB_MST_TIMEOUT_EN
  task automatic test_timeout();
    run_cmd(1'b0, 32'h8000_0020, 2'd2, 32'h0, 1000, 0, 1'b0, 32'h0);
    checks++; if (obs_lat !== TMO + 1) begin failures++; $display("FAIL tmo_latency got=%0d exp=%0d", obs_lat, TMO + 1); end
    checks++; if (obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
      failures++; $display("FAIL tmo_rsp got err=%b rdata=%h exp 1/0", obs_err, obs_rdata); end
    checks++; if (timeout_flag !== 1'b1) begin failures++; $display("FAIL tmo_flag_set got=%b exp=1", timeout_flag); end
    run_cmd(1'b0, 32'h8000_0024, 2'd2, 32'h0, 0, 0, 1'b0, 32'h1357_9BDF);
    checks++; if (timeout_flag !== 1'b0 || obs_err !== 1'b0 || obs_rdata !== 32'h1357_9BDF) begin
      failures++; $display("FAIL tmo_flag_clear got flag=%b err=%b rdata=%h exp 0/0/13579bdf",
                           timeout_flag, obs_err, obs_rdata); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef AHB_MST_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
